// File: rtl/conv_encoder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv_encoder_if
// Purpose  : Bit-in / symbol-out handshake bundle of the convolutional encoder.
// Revision : 1.0  initial release
// ============================================================================
interface conv_encoder_if;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_sym;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_sym, out_valid, out_last
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_sym, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv_encoder
// Purpose  : Rate-1/2 K=3 convolutional encoder (G0=111, G1=101), framed,
//            2 zero tail bits. Optional macro ERR_INJ_EN adds err_mask port.
// Revision : 1.0  initial release
// ============================================================================
module conv_encoder #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start,
`ifdef ERR_INJ_EN
    input  wire logic [1:0] err_mask,
`endif
    conv_encoder_if.slave   enc,
    output logic            busy,
    output logic            frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_sreg;      // {s1,s0}: s1 newest past bit
    logic [1:0]       w_sreg_nxt;
    logic [1:0]       r_sym;
    logic             r_valid;
    logic             r_last;
    logic             w_slot_free;
    logic             w_load;
    logic             w_u;
    logic             w_last;
    logic             w_in_ready;
    logic             w_done;
    logic [1:0]       w_mask;
    logic [1:0]       w_sym;

`ifdef ERR_INJ_EN
    assign w_mask = err_mask;
`else
    assign w_mask = 2'b00;
`endif

    assign w_slot_free = !r_valid || enc.out_ready;
    assign w_sym       = {w_u ^ r_sreg[1] ^ r_sreg[0], w_u ^ r_sreg[0]} ^ w_mask;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sreg_nxt  = r_sreg;
        w_load      = 1'b0;
        w_u         = 1'b0;
        w_last      = 1'b0;
        w_in_ready  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_sreg_nxt  = 2'b00;
                end
            end
            S_DATA: begin
                w_in_ready = w_slot_free;
                if (enc.in_valid && w_slot_free) begin
                    w_load     = 1'b1;
                    w_u        = enc.in_bit;
                    w_sreg_nxt = {enc.in_bit, r_sreg[1]};
                    if (r_cnt == c_last_bit) begin
                        w_state_nxt = S_TAIL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            S_TAIL: begin
                // Zero tail is injected without waiting for any input.
                if (w_slot_free) begin
                    w_load     = 1'b1;
                    w_sreg_nxt = {1'b0, r_sreg[1]};
                    if (r_cnt == c_one) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            S_FLUSH: begin
                if (r_valid && enc.out_ready && r_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sreg  <= 2'b00;
            r_sym   <= 2'b00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sreg  <= w_sreg_nxt;
            if (w_load) begin
                r_sym   <= w_sym;
                r_valid <= 1'b1;
                r_last  <= w_last;
            end else if (enc.out_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign enc.in_ready  = w_in_ready;
    assign enc.out_sym   = r_sym;
    assign enc.out_valid = r_valid;
    assign enc.out_last  = r_last;
    assign busy          = (r_state != S_IDLE) || r_valid;
    assign frame_done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv_encoder
// Purpose  : Random-frame bench for conv_encoder (FRAME_LEN=4 and FRAME_LEN=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic       start_d[2];
    logic       in_bit_d[2];
    logic       in_valid_d[2];
    logic       out_ready_d[2];
    logic       in_ready_w[2];
    logic       out_valid_w[2];
    logic       out_last_w[2];
    logic [1:0] out_sym_w[2];
    logic       busy_w[2];
    logic       done_w[2];
`ifdef ERR_INJ_EN
    logic [1:0] mask_d[2];
`endif

    conv_encoder_if u_if0();
    conv_encoder_if u_if1();

    assign u_if0.in_bit    = in_bit_d[0];
    assign u_if0.in_valid  = in_valid_d[0];
    assign u_if0.out_ready = out_ready_d[0];
    assign u_if1.in_bit    = in_bit_d[1];
    assign u_if1.in_valid  = in_valid_d[1];
    assign u_if1.out_ready = out_ready_d[1];
    assign in_ready_w[0]   = u_if0.in_ready;
    assign out_valid_w[0]  = u_if0.out_valid;
    assign out_last_w[0]   = u_if0.out_last;
    assign out_sym_w[0]    = u_if0.out_sym;
    assign in_ready_w[1]   = u_if1.in_ready;
    assign out_valid_w[1]  = u_if1.out_valid;
    assign out_last_w[1]   = u_if1.out_last;
    assign out_sym_w[1]    = u_if1.out_sym;

    conv_encoder #(.FRAME_LEN(4), .CNT_W(3)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_d[0]),
`ifdef ERR_INJ_EN
        .err_mask   (mask_d[0]),
`endif
        .enc        (u_if0),
        .busy       (busy_w[0]),
        .frame_done (done_w[0])
    );

    conv_encoder #(.FRAME_LEN(1), .CNT_W(2)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_d[1]),
`ifdef ERR_INJ_EN
        .err_mask   (mask_d[1]),
`endif
        .enc        (u_if1),
        .busy       (busy_w[1]),
        .frame_done (done_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected stream {last, c0, c1}: symbol i depends on bits i, i-1, i-2 of
    // the zero-padded, zero-tailed frame.
    logic [2:0] exp_q0[$];
    logic [2:0] exp_q1[$];

    task automatic push_exp(input int k, input int n, input logic [15:0] bits,
                            input logic [1:0] mask_first);
        for (int i = 0; i < n + 2; i++) begin
            logic u, u1, u2;
            logic [1:0] s;
            u  = (i < n) ? bits[i] : 1'b0;
            u1 = (i >= 1 && i - 1 < n) ? bits[i-1] : 1'b0;
            u2 = (i >= 2 && i - 2 < n) ? bits[i-2] : 1'b0;
            s  = {u ^ u1 ^ u2, u ^ u2};
`ifdef ERR_INJ_EN
            if (i == 0) s = s ^ mask_first;
`else
            if (i == 0) s = s ^ (mask_first & 2'b00);
`endif
            if (k == 0) exp_q0.push_back({(i == n + 1), s});
            else        exp_q1.push_back({(i == n + 1), s});
        end
    endtask

    int         n_done[2] = '{0, 0};
    int         n_xfer[2] = '{0, 0};
    logic       stalled[2] = '{1'b0, 1'b0};
    logic [2:0] held[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                stalled[k] <= 1'b0;
            end else begin
                if (stalled[k] && out_valid_w[k])
                    chk("hold_stable", {out_last_w[k], out_sym_w[k]}, held[k]);
                stalled[k] <= out_valid_w[k] && !out_ready_d[k];
                held[k]    <= {out_last_w[k], out_sym_w[k]};
                if (out_valid_w[k] && !out_ready_d[k])
                    chk("stall_in_ready", in_ready_w[k], 1'b0);
                if (out_valid_w[k] && out_ready_d[k]) begin
                    logic [2:0] e;
                    int sz;
                    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
                    chk("exp_available", (sz > 0), 1'b1);
                    if (sz > 0) begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk("symbol", {out_last_w[k], out_sym_w[k]}, e);
                    end
                    chk("done_with_last", done_w[k], out_last_w[k]);
                    n_xfer[k] <= n_xfer[k] + 1;
                end
                if (done_w[k]) n_done[k] <= n_done[k] + 1;
            end
        end
    end

    task automatic run(input int k, input int n, input logic [15:0] bits,
                       input int vld_pct, input int rdy_pct, input bit extra_start,
                       input logic [1:0] mask_first, input bit pre_started, input bit chain);
        int idx = 0;
        int cyc = 0;
        int done0;
        bit acc;
        bit acc_prev = 1'b0;
        done0 = n_done[k];
        push_exp(k, n, bits, mask_first);
        if (!pre_started) begin
            start_d[k] = 1'b1;
            @(posedge clk); #1;
        end
        start_d[k] = 1'b0;
        while (n_done[k] == done0 && cyc < 400) begin
            in_valid_d[k]  = (idx < n) && ($urandom_range(0, 99) < vld_pct);
            in_bit_d[k]    = (idx < n) ? bits[idx] : 1'($urandom);
            out_ready_d[k] = ($urandom_range(0, 99) < rdy_pct);
            start_d[k]     = extra_start && ($urandom_range(0, 3) == 0);
`ifdef ERR_INJ_EN
            mask_d[k]      = (idx == 0) ? mask_first : 2'b00;
`endif
            @(negedge clk);
            chk("busy_in_frame", busy_w[k], 1'b1);
            if (acc_prev) chk("latency", out_valid_w[k], 1'b1);
            acc = in_valid_d[k] && in_ready_w[k];
            @(posedge clk); #1;
            if (acc) idx++;
            acc_prev = acc;
            cyc++;
        end
        chk("frame_done_once", n_done[k] - done0, 1);
        chk("bits_taken", idx, n);
        chk("exp_drained", (k == 0) ? exp_q0.size() : exp_q1.size(), 0);
        // Idle cycle: in_valid must be ignored; optionally chain the next start.
        in_valid_d[k]  = 1'b1;
        in_bit_d[k]    = 1'($urandom);
        out_ready_d[k] = 1'b1;
        start_d[k]     = chain;
`ifdef ERR_INJ_EN
        mask_d[k]      = 2'b00;
`endif
        @(negedge clk);
        chk("idle_busy", busy_w[k], 1'b0);
        chk("idle_in_ready", in_ready_w[k], 1'b0);
        chk("idle_out_valid", out_valid_w[k], 1'b0);
        @(posedge clk); #1;
        start_d[k]    = 1'b0;
        in_valid_d[k] = 1'b0;
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_out_sym", out_sym_w[k], 2'b00);
        chk("rst_out_valid", out_valid_w[k], 1'b0);
        chk("rst_out_last", out_last_w[k], 1'b0);
        chk("rst_in_ready", in_ready_w[k], 1'b0);
        chk("rst_busy", busy_w[k], 1'b0);
        chk("rst_frame_done", done_w[k], 1'b0);
    endtask

    initial begin
        logic [15:0] bits;
        int idx, cyc, xf0, d0;
        bit acc;
        for (int k = 0; k < 2; k++) begin
            start_d[k] = 1'b0; in_bit_d[k] = 1'b0;
            in_valid_d[k] = 1'b0; out_ready_d[k] = 1'b1;
`ifdef ERR_INJ_EN
            mask_d[k] = 2'b00;
`endif
        end
        #12;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed frame 1,0,1,1 with full throughput, then with stalls.
        run(0, 4, 16'b1101, 100, 100, 1'b0, 2'b00, 1'b0, 1'b0);
        run(0, 4, 16'b1101, 100, 40, 1'b1, 2'b00, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++)
            run(0, 4, 16'($urandom), $urandom_range(30, 100), $urandom_range(30, 100),
                1'($urandom), 2'b00, 1'b0, 1'b0);

        // Reset after the second accepted symbol.
        bits = 16'($urandom);
        push_exp(0, 4, bits, 2'b00);
        start_d[0] = 1'b1;
        @(posedge clk); #1;
        start_d[0] = 1'b0;
        xf0 = n_xfer[0]; d0 = n_done[0]; idx = 0; cyc = 0;
        while (n_xfer[0] - xf0 < 2 && cyc < 20) begin
            in_valid_d[0] = (idx < 4);
            in_bit_d[0] = bits[idx];
            out_ready_d[0] = 1'b1;
            @(negedge clk);
            acc = in_valid_d[0] && in_ready_w[0];
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        chk("rst_pre_xfer", n_xfer[0] - xf0, 2);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs(0);
        exp_q0.delete();
        in_valid_d[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_no_done", n_done[0] - d0, 0);
        run(0, 4, 16'($urandom), 100, 100, 1'b0, 2'b00, 1'b0, 1'b0);

        // FRAME_LEN=1, back-to-back starts on the cycle after frame_done.
        run(1, 1, 16'h0001, 100, 100, 1'b0, 2'b00, 1'b0, 1'b1);
        run(1, 1, 16'($urandom), 100, 100, 1'b0, 2'b00, 1'b1, 1'b1);
        run(1, 1, 16'($urandom), 70, 50, 1'b1, 2'b00, 1'b1, 1'b0);

`ifdef ERR_INJ_EN
        run(0, 4, 16'b1101, 100, 100, 1'b0, 2'b01, 1'b0, 1'b0);
        run(0, 4, 16'($urandom), 80, 60, 1'b0, 2'($urandom), 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
